neuron_lut_sequencer: RTL and testbench

- Time-multiplexed LogicNets layer engine: one programmable truth-table RAM serves N_NEURONS neurons, evaluated one neuron per cycle.
- Per neuron: gathers FAN_IN quantised activations from the input vector via a programmable connection table, forms the LUT address, latches the OUT_BITS result into the output vector.
- Sits between two layer-activation registers with valid/ready streams; a config port loads truth tables and connectivity in place of fixed per-neuron ROM modules.

---
 rtl/neuron_seq_pkg.sv | 27 ++
 rtl/neuron_lut_ram.sv | 25 ++
 rtl/neuron_lut_sequencer.sv | 133 +++++++++++++
 tb/tb_neuron_lut_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_seq_pkg.sv
// Shared widths and the sequencer state type for the time-multiplexed LogicNets layer engine.
package neuron_seq_pkg;

  localparam int unsigned IN_BITS   = 2;
  localparam int unsigned FAN_IN    = 4;
  localparam int unsigned N_IN      = 16;
  localparam int unsigned N_NEURONS = 8;
  localparam int unsigned OUT_BITS  = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned ADDR_W    = IN_BITS * FAN_IN;
  localparam int unsigned NIDX_W    = $clog2(N_NEURONS);
  localparam int unsigned CIDX_W    = $clog2(N_IN);
  localparam int unsigned FIDX_W    = $clog2(FAN_IN);
  // One extra bit so an index >= N_IN (reads as zero) can actually be programmed.
  localparam int unsigned CONN_W    = CIDX_W + 1;
  localparam int unsigned CONN_A_W  = NIDX_W + FIDX_W;
  localparam int unsigned CFG_A_W   = NIDX_W + ADDR_W;
  localparam int unsigned CFG_D_W   = max_u(OUT_BITS, CONN_W);
  localparam int unsigned LUT_DEPTH = N_NEURONS << ADDR_W;

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StHold} state_e;

endpackage

// File: rtl/neuron_lut_ram.sv
// Truth-table storage for all neurons: one write port, registered read, contents survive reset.
module neuron_lut_ram
  import neuron_seq_pkg::*;
(
  input  logic                clk,
  input  logic                we_i,
  input  logic [CFG_A_W-1:0]  waddr_i,
  input  logic [OUT_BITS-1:0] wdata_i,
  input  logic [CFG_A_W-1:0]  raddr_i,
  output logic [OUT_BITS-1:0] rdata_o
);

  logic [OUT_BITS-1:0] mem_q [LUT_DEPTH];
  logic [OUT_BITS-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/neuron_lut_sequencer.sv
// Evaluates N_NEURONS LUT neurons one per cycle from a shared truth-table RAM and a
// programmable connection table, between valid/ready input and output vector registers.
module neuron_lut_sequencer
  import neuron_seq_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [N_IN*IN_BITS-1:0]       s_data_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [N_NEURONS*OUT_BITS-1:0] m_data_o,
  input  logic                          cfg_we_i,
  input  logic                          cfg_sel_i,
  input  logic [CFG_A_W-1:0]            cfg_addr_i,
  input  logic [CFG_D_W-1:0]            cfg_wdata_i,
  output logic                          cfg_drop_o,
  output logic                          busy_o
);

  state_e              state_q;
  logic [NIDX_W-1:0]   k_q;
  logic [IN_BITS-1:0]  act_q [N_IN];
  logic [OUT_BITS-1:0] out_q [N_NEURONS];
  logic                m_valid_q;
  logic                cfg_drop_q;
  logic [CONN_W-1:0]   conn_q [N_NEURONS*FAN_IN];

  logic                idle;
  logic                cfg_ok;
  logic [ADDR_W-1:0]   lut_addr;
  logic [CONN_W-1:0]   conn_sel;
  logic [IN_BITS-1:0]  act_sel;
  logic [OUT_BITS-1:0] lut_rdata;

  assign idle   = (state_q == StIdle);
  assign cfg_ok = cfg_we_i && idle;

  always_ff @(posedge clk) begin
    if (cfg_ok && cfg_sel_i) begin
      conn_q[cfg_addr_i[CONN_A_W-1:0]] <= cfg_wdata_i[CONN_W-1:0];
    end
  end

  // Gather the fan-in activations of neuron k_q; fan-in 0 lands in the address LSBs.
  always_comb begin
    lut_addr = '0;
    conn_sel = '0;
    act_sel  = '0;
    for (int f = 0; f < FAN_IN; f++) begin
      conn_sel = conn_q[{k_q, FIDX_W'(f)}];
      act_sel  = '0;
      if (conn_sel < CONN_W'(N_IN)) begin
        act_sel = act_q[conn_sel[CIDX_W-1:0]];
      end
      lut_addr[f*IN_BITS +: IN_BITS] = act_sel;
    end
  end

  neuron_lut_ram u_lut_ram (
    .clk     (clk),
    .we_i    (cfg_ok && !cfg_sel_i),
    .waddr_i (cfg_addr_i),
    .wdata_i (cfg_wdata_i[OUT_BITS-1:0]),
    .raddr_i ({k_q, lut_addr}),
    .rdata_o (lut_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      k_q        <= '0;
      m_valid_q  <= 1'b0;
      cfg_drop_q <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        act_q[i] <= '0;
      end
      for (int n = 0; n < N_NEURONS; n++) begin
        out_q[n] <= '0;
      end
    end else begin
      cfg_drop_q <= cfg_we_i && !idle;
      unique case (state_q)
        StIdle: begin
          if (s_valid_i) begin
            for (int i = 0; i < N_IN; i++) begin
              act_q[i] <= s_data_i[i*IN_BITS +: IN_BITS];
            end
            k_q     <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          // RAM data arriving now belongs to the neuron addressed last cycle.
          if (k_q != '0) begin
            out_q[k_q - NIDX_W'(1)] <= lut_rdata;
          end
          if (k_q == NIDX_W'(N_NEURONS - 1)) begin
            state_q <= StFlush;
          end else begin
            k_q <= k_q + NIDX_W'(1);
          end
        end
        StFlush: begin
          out_q[NIDX_W'(N_NEURONS - 1)] <= lut_rdata;
          m_valid_q                     <= 1'b1;
          state_q                       <= StHold;
        end
        StHold: begin
          if (m_ready_i) begin
            m_valid_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    m_data_o = '0;
    for (int n = 0; n < N_NEURONS; n++) begin
      m_data_o[n*OUT_BITS +: OUT_BITS] = out_q[n];
    end
  end

  assign s_ready_o  = idle;
  assign busy_o     = !idle;
  assign m_valid_o  = m_valid_q;
  assign cfg_drop_o = cfg_drop_q;

endmodule

// File: tb/tb_neuron_lut_sequencer.sv
// Randomised self-checking bench for neuron_lut_sequencer against a table-level reference model.
module tb_neuron_lut_sequencer;
  import neuron_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [31:0] s_data;
  logic [15:0] m_data;
  logic        cfg_we, cfg_sel, cfg_drop, busy;
  logic [10:0] cfg_addr;
  logic [4:0]  cfg_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] lut_m  [8][256];
  int         conn_m [8][4];

  always #5 clk = ~clk;

  neuron_lut_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .s_data_i    (s_data),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .m_data_o    (m_data),
    .cfg_we_i    (cfg_we),
    .cfg_sel_i   (cfg_sel),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .cfg_drop_o  (cfg_drop),
    .busy_o      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_addr(input int k, input logic [31:0] sd);
    int a = 0;
    for (int f = 0; f < 4; f++) begin
      int c = conn_m[k][f];
      int x = (c < 16) ? int'((sd >> (2 * c)) & 32'd3) : 0;
      a += x << (2 * f);
    end
    return a;
  endfunction

  function automatic logic [15:0] model_out(input logic [31:0] sd);
    logic [15:0] r = '0;
    for (int k = 0; k < 8; k++) begin
      r |= 16'(lut_m[k][model_addr(k, sd)]) << (2 * k);
    end
    return r;
  endfunction

  task automatic lut_wr(input int k, input int a, input int v);
    cfg_sel = 1'b0; cfg_addr = 11'((k << 8) | a); cfg_wdata = 5'(v); cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    lut_m[k][a] = 2'(v);
  endtask

  task automatic conn_wr(input int k, input int f, input int idx);
    cfg_sel = 1'b1; cfg_addr = 11'(k * 4 + f); cfg_wdata = 5'(idx); cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    conn_m[k][f] = idx;
  endtask

  task automatic send(input string tag, input logic [31:0] sd);
    check_eq({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    s_data = sd; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int n = 0;
    while (!m_valid && n < 40) begin
      tick();
      n++;
    end
    check_eq({tag, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic release_out(input string tag);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check_eq({tag, "_m_valid_clr"}, 32'(m_valid), 32'd0);
  endtask

  task automatic run_check(input string tag, input logic [31:0] sd);
    send(tag, sd);
    wait_valid(tag, 9);
    check_eq({tag, "_m_data"}, 32'(m_data), 32'(model_out(sd)));
    release_out(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] sd_id, sd, sd2;
    logic [15:0] first;
    int          a3;

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) tick();
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_data", 32'(m_data), 32'd0);
    check_eq("rst_cfg_drop", 32'(cfg_drop), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("rst_s_ready", 32'(s_ready), 32'd1);

    // Identity network
    for (int k = 0; k < 8; k++) begin
      for (int a = 0; a < 256; a++) lut_wr(k, a, a & 3);
      conn_wr(k, 0, k);
      for (int f = 1; f < 4; f++) conn_wr(k, f, 0);
    end
    sd_id = '0;
    for (int i = 0; i < 16; i++) sd_id |= 32'(i % 4) << (2 * i);
    send("ident", sd_id);
    check_eq("ident_busy", 32'(busy), 32'd1);
    wait_valid("ident", 9);
    check_eq("ident_m_data", 32'(m_data), 32'h0000_E4E4);
    check_eq("ident_model", 32'(m_data), 32'(model_out(sd_id)));
    release_out("ident");

    // Reset part-way through RUN
    send("rstrun", 32'h1234_5678);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check_eq("rstrun_m_valid", 32'(m_valid), 32'd0);
    check_eq("rstrun_m_data", 32'(m_data), 32'd0);
    check_eq("rstrun_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rstrun_s_ready", 32'(s_ready), 32'd1);
    send("ident2", sd_id);
    wait_valid("ident2", 9);
    check_eq("ident2_m_data", 32'(m_data), 32'h0000_E4E4);
    release_out("ident2");

    // Config write while busy is dropped
    send("drop", 32'h0);
    repeat (2) tick();
    cfg_sel = 1'b0; cfg_addr = 11'h000; cfg_wdata = 5'd3; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    check_eq("drop_pulse", 32'(cfg_drop), 32'd1);
    tick();
    check_eq("drop_pulse_end", 32'(cfg_drop), 32'd0);
    wait_valid("drop", 5);
    first = m_data;
    check_eq("drop_m_data", 32'(m_data), 32'(model_out(32'h0)));
    release_out("drop");
    send("drop_rerun", 32'h0);
    wait_valid("drop_rerun", 9);
    check_eq("drop_rerun_same", 32'(m_data), 32'(first));
    release_out("drop_rerun");

    // Backpressure
    sd = $urandom; sd2 = $urandom;
    send("bp", sd);
    wait_valid("bp", 9);
    first = m_data;
    check_eq("bp_m_data", 32'(m_data), 32'(model_out(sd)));
    s_data = sd2; s_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      check_eq("bp_hold_data", 32'(m_data), 32'(first));
      check_eq("bp_hold_s_ready", 32'(s_ready), 32'd0);
      check_eq("bp_hold_m_valid", 32'(m_valid), 32'd1);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check_eq("bp_idle_m_valid", 32'(m_valid), 32'd0);
    check_eq("bp_idle_s_ready", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    check_eq("bp_second_accept", 32'(busy), 32'd1);
    wait_valid("bp2", 9);
    check_eq("bp2_m_data", 32'(m_data), 32'(model_out(sd2)));
    release_out("bp2");

    // Address ordering: fan-in 3 drives the address MSBs
    for (int a = 0; a < 256; a++) lut_wr(0, a, (a == 8'b0100_0000) ? 3 : 0);
    conn_wr(0, 3, 5);
    for (int f = 0; f < 3; f++) conn_wr(0, f, 0);
    send("order_a", 32'h1 << 10);
    wait_valid("order_a", 9);
    check_eq("order_a_slot0", 32'(m_data[1:0]), 32'd3);
    check_eq("order_a_m_data", 32'(m_data), 32'(model_out(32'h1 << 10)));
    release_out("order_a");
    send("order_b", 32'h1);
    wait_valid("order_b", 9);
    check_eq("order_b_slot0", 32'(m_data[1:0]), 32'd0);
    release_out("order_b");

    // Out-of-range connection index reads activation 0
    for (int f = 0; f < 4; f++) conn_wr(2, f, 20);
    lut_wr(2, 0, 2);
    for (int t = 0; t < 3; t++) begin
      sd = $urandom;
      send("oor", sd);
      wait_valid("oor", 9);
      check_eq("oor_slot2", 32'(m_data[5:4]), 32'd2);
      check_eq("oor_m_data", 32'(m_data), 32'(model_out(sd)));
      release_out("oor");
    end

    // Randomised tables and vectors
    for (int k = 0; k < 8; k++) begin
      for (int a = 0; a < 256; a++) lut_wr(k, a, int'($urandom_range(0, 3)));
      for (int f = 0; f < 4; f++) conn_wr(k, f, int'($urandom_range(0, 19)));
    end
    for (int t = 0; t < 12; t++) begin
      conn_wr(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 19)));
      for (int w = 0; w < 4; w++) begin
        lut_wr(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 3)));
      end
      run_check("rand", $urandom);
    end

    // Config write coinciding with accept lands before the inference
    sd = $urandom;
    a3 = model_addr(3, sd);
    cfg_sel = 1'b0; cfg_addr = 11'((3 << 8) | a3); cfg_wdata = 5'(~lut_m[3][a3] & 2'd3);
    cfg_we = 1'b1; s_data = sd; s_valid = 1'b1;
    tick();
    lut_m[3][a3] = ~lut_m[3][a3];
    cfg_we = 1'b0; s_valid = 1'b0;
    wait_valid("coincide", 9);
    check_eq("coincide_m_data", 32'(m_data), 32'(model_out(sd)));
    release_out("coincide");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
